// File: rtl/hp_logger_pkg.sv
// Register map, CTRL/STATUS field positions and limits shared by the alarm logger
// top level and its bench.
package hp_logger_pkg;

  typedef enum logic [3:0] {
    OFF_STATUS = 4'h0,
    OFF_DATA   = 4'h4,
    OFF_CTRL   = 4'h8,
    OFF_TIME   = 4'hC
  } reg_off_e;

  localparam int EN     = 0;
  localparam int CLR    = 1;
  localparam int IRQ_EN = 2;

  localparam int ST_LEVEL_LSB = 0;
  localparam int ST_LEVEL_W   = 9;
  localparam int ST_EMPTY     = 9;
  localparam int ST_FULL      = 10;
  localparam int ST_OVF_LSB   = 16;
  localparam int ST_OVF_W     = 8;

  localparam logic [7:0] OVF_MAX = 8'd255;

  function automatic logic [31:0] pack_status(
    input logic [ST_LEVEL_W-1:0] level,
    input logic                  empty,
    input logic                  full,
    input logic [ST_OVF_W-1:0]   ovf
  );
    logic [31:0] s;
    s = '0;
    s[ST_LEVEL_LSB +: ST_LEVEL_W] = level;
    s[ST_EMPTY]                   = empty;
    s[ST_FULL]                    = full;
    s[ST_OVF_LSB +: ST_OVF_W]     = ovf;
    return s;
  endfunction

endpackage

// File: rtl/hp_sync_fifo.sv
// Single-clock FIFO with a registered head word that is valid whenever the FIFO
// is non-empty; a pop in the same cycle frees room for a push even when full.
module hp_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level,
  output logic             push_ok
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_next;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_next = rd_ptr_q + AW'(1);

  assign head    = head_q;
  assign level   = level_q;
  assign push_ok = do_push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
    head_d   = head_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_next;
    // The head register tracks mem[rd_ptr]; a push into an otherwise-empty FIFO bypasses memory.
    if (do_push && (empty || (do_pop && level_q == LW'(1)))) begin
      head_d = push_data;
    end else if (do_pop && level_q > LW'(1)) begin
      head_d = mem[rd_next];
    end
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/hp_alarm_logger.sv
// Timestamps each rising edge of the glitch detector alarm into a FIFO that
// firmware drains through a four-register Wishbone window.
module hp_alarm_logger
  import hp_logger_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          TS_W      = 24,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0010
) (
  input  logic        wb_clk_i,
  input  logic        reset,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_stl_o,
  output logic [31:0] wbs_dat_o,
  input  logic        alarm_i,
  output logic        irq_o
);

  localparam int LW = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  logic [2:0]      sync_q, sync_d;
  logic            event_q, event_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [7:0]      ovf_q, ovf_d;
  logic            en_q, en_d;
  logic            irq_en_q, irq_en_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic            irq_q, irq_d;

  logic            sel, accept, bus_wr, bus_rd, clr_wr;
  reg_off_e        off;
  logic [31:0]     rdata;

  logic            fifo_push, fifo_pop, fifo_push_ok;
  logic            fifo_full, fifo_empty;
  logic [LW-1:0]   fifo_level;
  logic [TS_W-1:0] fifo_head;

  logic            unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:3]};

  // sync_q[1] is the synchronized alarm, sync_q[2] its previous value.
  always_comb begin
    sync_d  = {sync_q[1:0], alarm_i};
    event_d = sync_q[1] && !sync_q[2];
  end

  always_comb begin
    sel       = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    accept    = sel && !ack_q;
    off       = reg_off_e'({wbs_adr_i[3:2], 2'b00});
    bus_wr    = accept && wbs_we_i;
    bus_rd    = accept && !wbs_we_i;
    clr_wr    = bus_wr && (off == OFF_CTRL) && wbs_dat_i[CLR];
    fifo_pop  = bus_rd && (off == OFF_DATA) && !fifo_empty;
    fifo_push = event_q && en_q && !clr_wr;
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_STATUS: rdata = pack_status(ST_LEVEL_W'(fifo_level), fifo_empty, fifo_full, ovf_q);
      OFF_DATA: begin
        if (!fifo_empty) begin
          rdata[31]       = 1'b1;
          rdata[TS_W-1:0] = fifo_head;
        end
      end
      OFF_CTRL: begin
        rdata[EN]     = en_q;
        rdata[IRQ_EN] = irq_en_q;
      end
      OFF_TIME: rdata[TS_W-1:0] = ts_q;
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    ts_d     = clr_wr ? '0 : ts_q + TS_W'(1);
    ovf_d    = ovf_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    if (clr_wr) begin
      ovf_d = '0;
    end else if (fifo_push && !fifo_push_ok && ovf_q != OVF_MAX) begin
      ovf_d = ovf_q + 8'd1;
    end
    if (bus_wr && off == OFF_CTRL) begin
      en_d     = wbs_dat_i[EN];
      irq_en_d = wbs_dat_i[IRQ_EN];
    end
    ack_d = accept;
    dat_d = bus_rd ? rdata : '0;
    irq_d = irq_en_q && !fifo_empty;
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      sync_q   <= '0;
      event_q  <= 1'b0;
      ts_q     <= '0;
      ovf_q    <= '0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      event_q  <= event_d;
      ts_q     <= ts_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
    end
  end

  hp_sync_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .srst      (reset),
    .clr       (clr_wr),
    .push      (fifo_push),
    .push_data (ts_q),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .push_ok   (fifo_push_ok)
  );

  // Stall mirrors ack so at most one request is in flight.
  assign wbs_ack_o = ack_q;
  assign wbs_stl_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_hp_alarm_logger.sv
// Scoreboard bench for hp_alarm_logger: bus tasks queue expected read data,
// a negedge monitor pops and compares on every ack.
module tb_hp_alarm_logger;

  localparam logic [31:0] BASE  = 32'h3000_0010;
  localparam int          DEPTH = 16;
  localparam logic [31:0] FULLM = 32'hFFFF_FFFF;

  logic        wb_clk_i = 1'b0;
  logic        reset    = 1'b1;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o, wbs_stl_o, irq_o;
  logic [31:0] wbs_dat_o;
  logic        alarm_i = 1'b0;

  always #5 wb_clk_i = ~wb_clk_i;

  hp_alarm_logger dut (
    .wb_clk_i  (wb_clk_i),
    .reset     (reset),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_stl_o (wbs_stl_o),
    .wbs_dat_o (wbs_dat_o),
    .alarm_i   (alarm_i),
    .irq_o     (irq_o)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic [31:0] mask;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;

  // Reference timestamp: cleared by reset and by an accepted CTRL.clr write.
  int unsigned tcnt = 0;
  bit          clr_pend = 1'b0;
  int unsigned mq[$];
  int          movf = 0;
  bit          m_en = 1'b0;

  always @(posedge wb_clk_i) begin
    if (reset || clr_pend) tcnt <= 0;
    else                   tcnt <= tcnt + 1;
  end

  always @(negedge wb_clk_i) begin
    if (wbs_ack_o) begin
      checks++;
      if (!wbs_stl_o) begin
        errors++;
        $display("FAIL stall_with_ack got=0 exp=1");
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack got dat=%h exp=no ack", wbs_dat_o);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.mask != 0) begin
          checks++;
          if ((wbs_dat_o & mon_e.mask) !== (mon_e.exp & mon_e.mask)) begin
            errors++;
            $display("FAIL %s got=%h exp=%h mask=%h", mon_e.name, wbs_dat_o, mon_e.exp, mon_e.mask);
          end else begin
            $display("txn %s read dat=%h ok", mon_e.name, wbs_dat_o);
          end
        end else begin
          $display("txn %s write acked", mon_e.name);
        end
      end
    end else begin
      checks++;
      if (wbs_dat_o !== 32'h0) begin
        errors++;
        $display("FAIL dat_idle got=%h exp=00000000", wbs_dat_o);
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end else begin
      $display("check %s = %h ok", n, got);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that ends the ack cycle.
  task automatic bus(input logic [31:0] a, input bit w, input logic [31:0] d,
                     input logic [31:0] exp, input logic [31:0] mask, input string n);
    exp_t e;
    bit   got;
    e.name = n;
    e.exp  = exp;
    e.mask = mask;
    sb.push_back(e);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = w;
    wbs_adr_i = a;
    wbs_dat_i = d;
    if (w && a[3:0] == 4'h8 && d[1]) clr_pend = 1'b1;
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b0;
    clr_pend  = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (wbs_ack_o) got = 1'b1;
      else begin
        @(posedge wb_clk_i); #1;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_ack got=none exp=ack within 8 cycles", n);
      sb.delete(sb.size() - 1);
    end else begin
      @(posedge wb_clk_i); #1;
    end
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic bus_nosel(input logic [31:0] a, input string n);
    bit seen = 1'b0;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = a;
    repeat (4) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) seen = 1'b1;
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    chk(n, {31'h0, seen}, 32'h0);
  endtask

  function automatic logic [31:0] st_exp();
    int lvl = mq.size();
    return {8'h0, 8'(movf), 5'h0, lvl == DEPTH, lvl == 0, 9'(lvl)};
  endfunction

  function automatic void model_event(input int unsigned ts);
    if (!m_en) return;
    if (mq.size() < DEPTH) mq.push_back(ts & 32'h00FF_FFFF);
    else if (movf < 255) movf++;
  endfunction

  task automatic rd_status(input string n);
    bus(BASE + 32'h0, 1'b0, 32'h0, st_exp(), FULLM, n);
  endtask

  task automatic rd_data(input string n);
    logic [31:0] e = 32'h0;
    if (mq.size() > 0) e = 32'h8000_0000 | mq.pop_front();
    bus(BASE + 32'h4, 1'b0, 32'h0, e, FULLM, n);
  endtask

  task automatic wr_ctrl(input logic [31:0] d, input string n);
    bus(BASE + 32'h8, 1'b1, d, 32'h0, 32'h0, n);
    m_en = d[0];
    if (d[1]) begin
      mq.delete();
      movf = 0;
    end
  endtask

  // Event reaches the FIFO with the timestamp of 3 cycles after the drive cycle.
  task automatic pulse(input int gap);
    model_event(tcnt + 3);
    alarm_i = 1'b1;
    @(posedge wb_clk_i); #1;
    alarm_i = 1'b0;
    repeat (gap) begin
      @(posedge wb_clk_i); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    logic [31:0] e;

    repeat (4) @(posedge wb_clk_i);
    #1;
    chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
    chk("rst_stl", {31'h0, wbs_stl_o}, 32'h0);
    chk("rst_dat", wbs_dat_o, 32'h0);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    reset = 1'b0;
    rd_status("rst_status");
    bus(BASE + 32'h8, 1'b0, 32'h0, 32'h0, FULLM, "rst_ctrl");
    bus(BASE + 32'hC, 1'b0, 32'h0, 32'h0, 32'hFFFF_FF00, "rst_time_small");

    // Three pulses 50 cycles apart, then drain including one empty read.
    wr_ctrl(32'h1, "ctrl_en");
    repeat (3) pulse(49);
    rd_status("status_3");
    repeat (4) rd_data("data_t1");

    // Level held high logs once.
    model_event(tcnt + 3);
    alarm_i = 1'b1;
    repeat (200) begin
      @(posedge wb_clk_i); #1;
    end
    alarm_i = 1'b0;
    repeat (6) begin
      @(posedge wb_clk_i); #1;
    end
    rd_status("status_hold");
    rd_data("data_hold");

    // Twenty pulses overflow the 16-entry FIFO by four.
    repeat (20) pulse(8);
    rd_status("status_full");
    rd_data("data_first");
    pulse(8);
    rd_status("status_refull");

    // DATA read accepted in the same cycle the event pushes.
    t = tcnt;
    alarm_i = 1'b1;
    @(posedge wb_clk_i); #1;
    alarm_i = 1'b0;
    repeat (2) begin
      @(posedge wb_clk_i); #1;
    end
    e = 32'h8000_0000 | mq.pop_front();
    mq.push_back((t + 3) & 32'h00FF_FFFF);
    bus(BASE + 32'h4, 1'b0, 32'h0, e, FULLM, "data_pop_push");
    repeat (5) begin
      @(posedge wb_clk_i); #1;
    end
    rd_status("status_pop_push");

    // Clear with five entries left; en drops, irq_en rises.
    while (mq.size() > 5) rd_data("data_drain");
    rd_status("status_5");
    wr_ctrl(32'h6, "ctrl_clr");
    rd_status("status_clr");
    bus(BASE + 32'h8, 1'b0, 32'h0, 32'h4, FULLM, "ctrl_after_clr");
    bus(BASE + 32'hC, 1'b0, 32'h0, 32'h0, 32'hFFFF_FF00, "time_after_clr");
    pulse(8);
    rd_status("status_en0");
    chk("irq_empty", {31'h0, irq_o}, 32'h0);

    // Interrupt follows non-empty with irq_en set.
    wr_ctrl(32'h5, "ctrl_irq");
    chk("irq_before", {31'h0, irq_o}, 32'h0);
    pulse(8);
    chk("irq_high", {31'h0, irq_o}, 32'h1);
    rd_data("data_irq");
    chk("irq_fall", {31'h0, irq_o}, 32'h0);

    // Read-only writes are ignored.
    bus(BASE + 32'h0, 1'b1, FULLM, 32'h0, 32'h0, "wr_status_ro");
    bus(BASE + 32'hC, 1'b1, FULLM, 32'h0, 32'h0, "wr_time_ro");
    bus(BASE + 32'h8, 1'b0, 32'h0, 32'h5, FULLM, "ctrl_kept");
    rd_status("status_final");
    bus(BASE + 32'hC, 1'b0, 32'h0, 32'h0, 32'hFFFF_0000, "time_not_written");

    bus_nosel(32'h3000_0000, "nosel_low");
    bus_nosel(32'h3000_0020, "nosel_high");

    repeat (5) @(posedge wb_clk_i);
    #1;
    chk("sb_drained", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hp_alarm_logger.md
Name: hp_alarm_logger

Overview:
- Downstream consumer of the glitch-detector core's alarm output (the hp_Alarm signal).
- Captures each rising edge of the alarm, stamps it with a free-running cycle counter, and buffers the stamps in a FIFO.
- Firmware drains the FIFO over the same Wishbone bus, at its own address window next to the detector's register.
- Gives firmware a time-ordered history of glitch hits; the detector alone provides only a latch and an 8-bit count.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- TS_W, 24, timestamp width in bits; 8..31.
- BASE_ADDR, 32'h3000_0010, base of the 16-byte register window; bits [3:0] must be 0.

Ports:
- wb_clk_i  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer complete.
- wbs_stl_o  out  1  cannot accept a request.
- wbs_dat_o  out  32  read data.
- alarm_i  in  1  detector alarm; may be asynchronous to wb_clk_i.
- irq_o  out  1  FIFO non-empty interrupt.

Behaviour:
- Interface: one clock, wb_clk_i; reset is synchronous and active-high.
- Reset values: wbs_ack_o=0, wbs_stl_o=0, wbs_dat_o=0, irq_o=0. FIFO empty, overflow count 0, timestamp 0, CTRL=0.
- Alarm input path:
  - alarm_i passes through a 2-flop synchronizer, then a rising-edge detector.
  - An event is a single-cycle pulse, 3 cycles after the alarm_i rise.
  - A level held high produces only one event.
- Timestamp: TS_W-bit counter, increments every cycle, wraps from all-ones to 0. It runs regardless of the enable bit.
- Capture:
  - On an event with CTRL.en=1: if the FIFO is not full, push the timestamp value of that cycle.
  - If full, increment the overflow count instead; it saturates at 255.
  - With en=0, events are ignored.
- Bus decode:
  - Selected when cyc&stb and adr[31:4]==BASE_ADDR[31:4]. Offset is adr[3:2].
  - Unselected requests get no ack, because another slave owns that address.
- Handshake:
  - Ack is registered: asserted exactly 1 cycle after acceptance, for 1 cycle.
  - wbs_stl_o is high in the cycle ack is high, so only one request is outstanding at a time.
  - A request seen while stall is high is not accepted.
  - wbs_dat_o is valid with ack and is 0 when ack is low.
- Registers:
  - 0x0 STATUS (RO): [8:0] level, [9] empty, [10] full, [23:16] overflow count.
  - 0x4 DATA (RO, pops):
    - Non-empty: [31]=1, [TS_W-1:0]=head entry, other bits 0; the entry is popped.
    - Empty: returns 0 and does not pop.
  - 0x8 CTRL (RW): [0] en, [2] irq_en. [1] clr is write-only and self-clearing; it reads 0.
  - 0xC TIME (RO): current timestamp.
  - Writes to read-only registers are acked and have no effect.
- Clear (write with [1]=1):
  - Next cycle: FIFO empty, overflow count 0, timestamp 0.
  - An event in the clear cycle is dropped.
  - The en and irq_en values in the same write are applied.
- Simultaneous push and pop:
  - Both happen and the level is unchanged.
  - When full, the pop frees a slot, so the event is pushed and overflow is not incremented.
  - When empty, the read returns 0 and the event is pushed.
- irq_o is registered: irq_en & !empty, with 1-cycle lag.
- Reset in the middle of a bus transfer: ack is dropped and the request is lost; the master must retry.

Decomposition:
- Package hp_logger_pkg holds:
  - register offsets OFF_STATUS=0x0, OFF_DATA=0x4, OFF_CTRL=0x8, OFF_TIME=0xC;
  - CTRL bit indices EN=0, CLR=1, IRQ_EN=2;
  - STATUS field positions;
  - OVF_MAX=255.
- Sub-module hp_sync_fifo: parameterized WIDTH/DEPTH, push/pop/full/empty/level, registered head output. It defines the rule that a pop makes room for a push in the same cycle.

Test Plan:
- Reset, write CTRL=0x1, pulse alarm_i 3 times 50 cycles apart -> STATUS level=3; three DATA reads return bit31=1 with timestamps differing by 50; a fourth read returns 0.
- Hold alarm_i high for 200 cycles -> exactly 1 entry logged.
- With en=1, 20 alarm pulses and no reads -> full=1, level=16, overflow=4; DATA read returns the first timestamp.
- FIFO full, DATA read in the same cycle as an event -> level stays 16 and overflow is unchanged.
- Write CTRL=0x6 while 5 entries are present -> next STATUS level=0, empty=1, overflow=0; TIME reads a small value; later events are not logged (en=0); irq_o=0.
- CTRL=0x5, one alarm -> irq_o goes high; after one DATA read irq_o falls 1 cycle later. A request to 0x3000_0000 gives no ack from this block.
